// File: rtl/uart_word_tx.sv
// Serialises a 32-bit ASCII word as four 8N1 UART bytes, optionally followed by CR LF.
// tx and busy are registered one cycle behind the FSM state, so the line falls one cycle after accept.
module uart_word_tx #(
   parameter int unsigned CLKS_PER_BIT = 234,
   parameter bit          APPEND_CRLF  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned NUM_BYTES = APPEND_CRLF ? 6 : 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [BAUD_W-1:0] r_baud, w_baud_nxt, w_baud_tick;
   logic [2:0]        r_bit, w_bit_nxt;
   logic [2:0]        r_byte_idx, w_byte_idx_nxt;
   logic [31:0]       r_word, w_word_nxt;
   logic              r_tx, w_tx_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_ready, w_ready_nxt;
   logic              w_baud_end;
   logic              w_last_byte;
   logic [7:0]        w_byte;

   assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   assign w_baud_tick = w_baud_end ? '0 : r_baud + BAUD_W'(1);
   assign w_last_byte = (r_byte_idx == 3'(NUM_BYTES - 1));

   // Current byte: word characters MSB-first, then the CR LF trailer.
   always_comb begin
      w_byte = 8'hFF;
      case (r_byte_idx)
         3'd0:    w_byte = r_word[31:24];
         3'd1:    w_byte = r_word[23:16];
         3'd2:    w_byte = r_word[15:8];
         3'd3:    w_byte = r_word[7:0];
         3'd4:    w_byte = 8'h0D;
         3'd5:    w_byte = 8'h0A;
         default: w_byte = 8'hFF;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_baud_nxt     = r_baud;
      w_bit_nxt      = r_bit;
      w_byte_idx_nxt = r_byte_idx;
      w_word_nxt     = r_word;
      w_tx_nxt       = 1'b1;
      w_busy_nxt     = (r_state != IDLE);

      case (r_state)
         IDLE: begin
            if (word_valid) begin
               w_state_nxt    = START;
               w_word_nxt     = word_in;
               w_baud_nxt     = '0;
               w_bit_nxt      = '0;
               w_byte_idx_nxt = '0;
            end
         end
         START: begin
            w_tx_nxt   = 1'b0;
            w_baud_nxt = w_baud_tick;
            if (w_baud_end) begin
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
            end
         end
         DATA: begin
            w_tx_nxt   = w_byte[r_bit];
            w_baud_nxt = w_baud_tick;
            if (w_baud_end) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         STOP: begin
            w_tx_nxt   = 1'b1;
            w_baud_nxt = w_baud_tick;
            if (w_baud_end) begin
               if (w_last_byte) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt    = START;
                  w_byte_idx_nxt = r_byte_idx + 3'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_ready_nxt = (w_state_nxt == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit      <= w_bit_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_word     <= w_word_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_ready    <= w_ready_nxt;
      end
   end

   assign word_ready = r_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: two instances (with and without CR LF) at 4 clocks per bit.
module tb_uart_word_tx;

   localparam int unsigned CPB = 4;

   logic        clk;
   logic        rst;
   logic [31:0] word_a, word_b;
   logic        valid_a, valid_b;
   logic        ready_a, ready_b;
   logic        tx_a, tx_b;
   logic        busy_a, busy_b;

   int vecs = 0;
   int miscompares = 0;

   uart_word_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b1)) dut_a (
      .clk(clk), .rst(rst), .word_in(word_a), .word_valid(valid_a),
      .word_ready(ready_a), .tx(tx_a), .busy(busy_a)
   );

   uart_word_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b0)) dut_b (
      .clk(clk), .rst(rst), .word_in(word_b), .word_valid(valid_b),
      .word_ready(ready_b), .tx(tx_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer a word at a negedge; returns at the negedge after the accepting edge.
   task automatic accept(input bit sel, input logic [31:0] w, input bit hold);
      @(negedge clk);
      chk("ready_before_accept", sel ? 32'(ready_b) : 32'(ready_a), 32'd1);
      if (sel) begin word_b = w; valid_b = 1'b1; end
      else     begin word_a = w; valid_a = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
         if (sel) valid_b = 1'b0; else valid_a = 1'b0;
      end
   endtask

   // Called at the negedge right after the accepting edge; checks every cycle of the frame.
   task automatic check_frame(input bit sel, input logic [31:0] w, input int nb,
                              input bit scramble, input bit pulse);
      logic [7:0] byt [6];
      int         busy_cnt;
      int         k, j;
      logic       exp_tx;
      byt[0] = w[31:24]; byt[1] = w[23:16]; byt[2] = w[15:8]; byt[3] = w[7:0];
      byt[4] = 8'h0D;    byt[5] = 8'h0A;
      busy_cnt = 0;
      chk("tx_accept_cycle",    sel ? 32'(tx_b)    : 32'(tx_a),    32'd1);
      chk("busy_accept_cycle",  sel ? 32'(busy_b)  : 32'(busy_a),  32'd0);
      chk("ready_accept_cycle", sel ? 32'(ready_b) : 32'(ready_a), 32'd0);
      for (int c = 0; c < nb * 40; c++) begin
         @(negedge clk);
         if (scramble) begin
            if (sel) word_b = $urandom; else word_a = $urandom;
         end
         if (pulse && c == 20) begin
            if (sel) begin word_b = 32'h30303030; valid_b = 1'b1; end
            else     begin word_a = 32'h30303030; valid_a = 1'b1; end
         end else if (pulse && c == 21) begin
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
         end
         k = c / 40;
         j = (c / int'(CPB)) % 10;
         exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : byt[k][j-1];
         chk($sformatf("tx c=%0d byte=%0d bit=%0d", c, k, j),
             sel ? 32'(tx_b) : 32'(tx_a), 32'(exp_tx));
         chk($sformatf("ready c=%0d", c), sel ? 32'(ready_b) : 32'(ready_a),
             32'(c == nb * 40 - 1));
         if (sel ? busy_b : busy_a) busy_cnt++;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'(nb * 40));
   endtask

   task automatic idle_check(input bit sel, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("idle_tx i=%0d", i),    sel ? 32'(tx_b)    : 32'(tx_a),    32'd1);
         chk($sformatf("idle_busy i=%0d", i),  sel ? 32'(busy_b)  : 32'(busy_a),  32'd0);
         chk($sformatf("idle_ready i=%0d", i), sel ? 32'(ready_b) : 32'(ready_a), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0;
      word_a = '0;    word_b = '0;
      #1;
      chk("rst_tx_a", 32'(tx_a), 32'd1);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_ready_a", 32'(ready_a), 32'd1);
      chk("rst_tx_b", 32'(tx_b), 32'd1);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // "pass" with CR LF
      accept(1'b0, 32'h70617373, 1'b0);
      check_frame(1'b0, 32'h70617373, 6, 1'b0, 1'b0);
      idle_check(1'b0, 3);

      // "fail" without CR LF
      accept(1'b1, 32'h6661696C, 1'b0);
      check_frame(1'b1, 32'h6661696C, 4, 1'b0, 1'b0);
      idle_check(1'b1, 3);

      // valid pulse mid-frame is dropped, no second frame follows
      accept(1'b0, 32'h5A3C0FF0, 1'b0);
      check_frame(1'b0, 32'h5A3C0FF0, 6, 1'b0, 1'b1);
      idle_check(1'b0, 50);

      // word_in churns every cycle after accept
      accept(1'b1, 32'hA5C3817E, 1'b0);
      check_frame(1'b1, 32'hA5C3817E, 4, 1'b1, 1'b0);
      idle_check(1'b1, 2);

      // valid held high: back-to-back frames separated by one idle cycle
      accept(1'b0, 32'h686F6C64, 1'b1);
      check_frame(1'b0, 32'h686F6C64, 6, 1'b0, 1'b0);
      @(negedge clk);
      valid_a = 1'b0;
      check_frame(1'b0, 32'h686F6C64, 6, 1'b0, 1'b0);
      idle_check(1'b0, 3);

      // reset during byte 2 data bit 3, then fresh frame
      accept(1'b0, 32'h70617373, 1'b0);
      repeat (98) @(negedge clk);
      chk("pre_rst_tx", 32'(tx_a), 32'd0);
      chk("pre_rst_busy", 32'(busy_a), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", 32'(tx_a), 32'd1);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_ready", 32'(ready_a), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      idle_check(1'b0, 2);
      accept(1'b0, 32'h41424344, 1'b0);
      check_frame(1'b0, 32'h41424344, 6, 1'b0, 1'b0);
      idle_check(1'b0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 234, giving the clk cycles per UART bit (27 MHz / 115200 baud); legal values are >= 2.
REQ-002 The block SHALL have parameter APPEND_CRLF, default 1; when 1, each word frame is followed by 0x0D then 0x0A.
REQ-003 Port: clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: word_in  input  32  four ASCII bytes from the core's tx_word; [31:24] is the first character.
REQ-006 Port: word_valid  input  1  word_in is offered for transmission.
REQ-007 Port: word_ready  output  1  block accepts a word this cycle.
REQ-008 Port: tx  output  1  UART serial line, idle high, 8N1.
REQ-009 Port: busy  output  1  high while a frame is being shifted out.

Function
REQ-010 A word SHALL be accepted on a posedge clk where word_valid and word_ready are both 1; word_in is latched into an internal 32-bit holding register at that edge.
REQ-011 word_ready SHALL be 1 only in state IDLE; word_valid while not IDLE is ignored, with no queuing.
REQ-012 Changes on word_in after acceptance SHALL NOT affect the frame in progress.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START (next byte) or IDLE (last byte) after CLKS_PER_BIT cycles.
REQ-014 tx SHALL be 1 in IDLE, 0 in START, the current data bit in DATA, and 1 in STOP; tx is a registered output.
REQ-015 tx SHALL fall on the first posedge clk after the accepting edge, giving 1-cycle latency.
REQ-016 Each bit SHALL be held exactly CLKS_PER_BIT cycles, using a baud counter of width $clog2(CLKS_PER_BIT) that wraps to 0 at CLKS_PER_BIT-1.
REQ-017 Data bits SHALL be sent LSB first within each byte.
REQ-018 Bytes SHALL be sent in the order word_in[31:24], [23:16], [15:8], [7:0], then 0x0D, 0x0A if APPEND_CRLF=1.
REQ-019 A byte index counter of 0..3 (or 0..5 with CRLF) SHALL select the byte; the index resets to 0 on each accept.
REQ-020 Bytes within a frame SHALL be back-to-back: the next START follows the previous STOP with no extra idle cycles.
REQ-021 busy SHALL be high from the cycle after accept through the final STOP bit, and low in IDLE.
REQ-022 Frame duration SHALL be exactly 10*CLKS_PER_BIT*N cycles, where N = 6 with CRLF and 4 without.
REQ-023 After the final STOP bit the block SHALL spend at least 1 cycle in IDLE with word_ready=1 before accepting again. With word_valid held high, the next START begins at stop end + 1 cycle.
REQ-024 A word_valid pulse of 1 cycle arriving while busy SHALL be dropped silently.

Reset
REQ-025 While rst=1, independent of clk, the block SHALL force: state=IDLE, tx=1, busy=0, word_ready=1, baud counter=0, bit counter=0, byte index=0, holding register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with tx high asynchronously.
REQ-027 After rst deasserts, the first accept SHALL start a fresh frame at byte 0.

Verification
REQ-028 Scenario, CLKS_PER_BIT=4, APPEND_CRLF=1: accept word_in="pass" (0x70617373) -> tx shows bytes 0x70,0x61,0x73,0x73,0x0D,0x0A. For 0x70 the bit sequence is 0,0,0,0,0,1,1,1,0,1 (start, LSB-first data, stop), each bit 4 cycles. busy is high for exactly 240 cycles.
REQ-029 Scenario, APPEND_CRLF=0, CLKS_PER_BIT=4: accept "fail" (0x6661696C) -> 4 bytes 0x66,0x61,0x69,0x6C; busy is high for 160 cycles; word_ready returns to 1 on the next cycle.
REQ-030 Scenario: pulse word_valid with "0000" at cycle 20 of an ongoing frame -> the pulse is ignored; the frame finishes with its original bytes; no second frame follows.
REQ-031 Scenario: hold word_valid=1 with a constant word -> consecutive frames are separated by exactly one stop bit plus 1 idle cycle of tx=1.
REQ-032 Scenario: assert rst during DATA bit 3 of byte 2 -> tx=1, busy=0, word_ready=1 in the same cycle. After release, accept of 0x41424344 ("ABCD") transmits starting at 0x41.
REQ-033 Scenario: change word_in every cycle after accept -> transmitted bytes equal the value latched at the accepting edge.
